// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory wait states and a retired-instruction counter.
// Optional macro ILLEGAL_OP_TRAP_EN: unknown opcodes park the FSM in TRAP and raise illegal_op.
module multicycle_control #(
  parameter int                    OPCODE_W = 6,
  parameter int                    CNT_W    = 32,
  parameter logic [OPCODE_W-1:0]   OP_RTYPE = 6'b000000,
  parameter logic [OPCODE_W-1:0]   OP_LW    = 6'b100011,
  parameter logic [OPCODE_W-1:0]   OP_SW    = 6'b101011,
  parameter logic [OPCODE_W-1:0]   OP_BEQ   = 6'b000100,
  parameter logic [OPCODE_W-1:0]   OP_ADDI  = 6'b001000,
  parameter logic [OPCODE_W-1:0]   OP_J     = 6'b000010
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic                illegal_op,
`endif
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                IRWrite,
  output logic [1:0]          PCSource,
  output logic [1:0]          ALUOp,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic                RegWrite,
  output logic                RegDst,
  output logic [3:0]          state,
  output logic                retire,
  output logic [CNT_W-1:0]    retired_cnt
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  // fetch marks FETCH so IRWrite/PCWrite can be qualified by mem_ready in the same cycle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       fetch;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic             r_retire;
  logic [CNT_W-1:0] r_cnt;
  state_t           w_next;
  logic             w_retire_ev;

  function automatic ctrl_t f_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.mem_read = 1'b1; c.fetch = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:    c.alu_src_b = 2'b11;
      S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_RD:    begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WR:    begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_R_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH:    begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01;
        c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      end
      S_JUMP:      begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      S_ADDI_EXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDI_WB:   c.reg_write = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_IDLE:      w_next = S_FETCH;
      S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_RTYPE:     w_next = S_R_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          OP_J:         w_next = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:  w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:    w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:    w_next = S_R_WB;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:      w_next = S_TRAP;
`endif
      default:     w_next = S_FETCH;
    endcase
  end

  // DECODE->FETCH only happens for an unrecognised opcode treated as a NOP, which still retires.
  always_comb begin
    w_retire_ev = 1'b0;
    if (w_next == S_FETCH) begin
      case (r_state)
        S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB, S_DECODE: w_retire_ev = 1'b1;
        default: w_retire_ev = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ctrl   <= '0;
      r_retire <= 1'b0;
      r_cnt    <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_op <= 1'b0;
`endif
    end else begin
      r_state  <= w_next;
      r_ctrl   <= f_decode(w_next);
      r_retire <= w_retire_ev;
      if (w_retire_ev) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_op <= (w_next == S_TRAP);
`endif
    end
  end

  assign PCWrite     = r_ctrl.pc_write | (r_ctrl.fetch & mem_ready);
  assign PCWriteCond = r_ctrl.pc_write_cond;
  assign IorD        = r_ctrl.iord;
  assign MemRead     = r_ctrl.mem_read;
  assign MemWrite    = r_ctrl.mem_write;
  assign MemtoReg    = r_ctrl.mem_to_reg;
  assign IRWrite     = r_ctrl.fetch & mem_ready;
  assign PCSource    = r_ctrl.pc_source;
  assign ALUOp       = r_ctrl.alu_op;
  assign ALUSrcA     = r_ctrl.alu_src_a;
  assign ALUSrcB     = r_ctrl.alu_src_b;
  assign RegWrite    = r_ctrl.reg_write;
  assign RegDst      = r_ctrl.reg_dst;
  assign state       = r_state;
  assign retire      = r_retire;
  assign retired_cnt = r_cnt;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- A Moore-style FSM, with mem_ready-qualified Mealy terms, sequences each instruction over 3-5 cycles. It drives the shared-memory/single-ALU datapath signals (IorD, IRWrite, PCWrite, PCWriteCond, PCSource, ALUSrcA/B) plus the classic RegDst/MemRead/MemtoReg/ALUOp/MemWrite/RegWrite.
- Adds memory wait-state handshake and a retired-instruction counter.
- Sits between the instruction register opcode field and the datapath mux/enable inputs.

Parameters:
OPCODE_W, 6, opcode field width
CNT_W, 32, retired-instruction counter width
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_J, 6'b000010, jump opcode

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  OPCODE_W  IR[31:26], sampled in DECODE
mem_ready  in  1  memory completes current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
IorD  out  1  memory address select, 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  1  register write data, 1=MDR
IRWrite  out  1  instruction register load
PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
ALUOp  out  2  00=add, 01=sub, 10=funct
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=4, 10=imm, 11=imm<<2
RegWrite  out  1  register file write enable
RegDst  out  1  1=rd, 0=rt
state  out  4  current state encoding (debug/verification)
retire  out  1  one-cycle pulse on the transition back to FETCH
retired_cnt  out  CNT_W  retired-instruction count

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, TRAP=13.
- Reset: state=IDLE, retired_cnt=0, retire=0. All control outputs are 0 in IDLE.
- Reset mid-instruction aborts immediately; retired_cnt is not incremented.
- IDLE -> FETCH unconditionally on the first clock after rst deasserts.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Holds in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - LW/SW -> MEM_ADDR
  - RTYPE -> R_EXEC
  - BEQ -> BRANCH
  - ADDI -> ADDI_EXEC
  - J -> JUMP
  - other -> see Optional Feature
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_RD if LW, MEM_WR if SW. Uses the opcode held stable from the IR.
- MEM_RD: MemRead=1, IorD=1. Holds until mem_ready, then -> MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. -> FETCH.
- MEM_WR: MemWrite=1, IorD=1. Holds until mem_ready, then -> FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. -> FETCH.
- JUMP: PCWrite=1, PCSource=10. -> FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. -> FETCH.
- Any output not listed for a state is 0. Unused encodings 14-15 -> FETCH with all outputs 0.
- Instruction latencies (cycles, with zero wait states):
  - LW 5
  - SW 4
  - R-type 4
  - ADDI 4
  - BEQ 3
  - J 3
  - Each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds 1.
- retire: registered, high for exactly the first cycle of FETCH following a terminal state (MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, ADDI_WB). Not asserted on IDLE->FETCH.
- retired_cnt: increments by 1 at each such transition, and is visible in that same first FETCH cycle. Wraps 2^CNT_W-1 -> 0 silently.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - Unrecognised opcode in DECODE -> TRAP. TRAP holds until reset, with all outputs 0.
  - Extra output port illegal_op (1 bit) = 1 in TRAP, otherwise 0.
  - No retire on entry to TRAP.
- Undefined:
  - Unrecognised opcode in DECODE -> FETCH (NOP behaviour). Counts as retired.
  - No TRAP state and no illegal_op port.

Test Plan:
- Reset: rst=1 for 3 cycles, then release -> state=0 with all controls 0; next cycle state=1, MemRead=1, ALUSrcB=01.
- R-type, mem_ready=1: opcode=000000 -> state sequence 1,2,7,8,1. R_WB has RegWrite=1, RegDst=1. retire pulses once; retired_cnt=1.
- LW with 2 wait states in MEM_RD: opcode=100011, mem_ready=0 for 2 cycles in state 4 -> sequence 1,2,3,4,4,4,5,1. MEM_WB has MemtoReg=1, RegWrite=1.
- Back-to-back SW (101011), BEQ (000100), J (000010), ADDI (001000):
  - SW: MEM_WR has MemWrite=1, IorD=1.
  - BEQ: BRANCH has PCWriteCond=1, ALUOp=01, PCSource=01.
  - J: JUMP has PCWrite=1, PCSource=10.
  - ADDI: ADDI_WB has RegWrite=1, RegDst=0.
  - retired_cnt=4 at the end.
- FETCH stall and reset mid-op:
  - mem_ready=0 in FETCH for 3 cycles -> IRWrite=PCWrite=0 throughout, state stays 1.
  - Then assert rst while in state 4 -> state=0 immediately (asynchronous), retired_cnt=0.
- Illegal opcode 111111:
  - With ILLEGAL_OP_TRAP_EN: state=13, illegal_op=1, held for 10 cycles, no retire.
  - Without the macro: 2 -> 1, retired_cnt increments.
